// File: rtl/bmp_scan_ctrl.sv
// Sequences one bitmap load, then 24 column scans and 32 top/bottom row-pair scans through the compare ALU.
// Latency: 226 cycles from start sample to done with 1-cycle ready/alu_done responses; every output is registered.
// Backpressure: stalls indefinitely on colready/rowready/alu_done; BMP_SCAN_WDOG_EN adds a TMO_CYC watchdog that aborts to ERR.
module bmp_scan_ctrl #(
    parameter int NCOLS   = 24,
    parameter int NROWS   = 64,
    parameter int CNTW    = 6,
    parameter int TMO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            bmp_wren,
    output logic            nextcol,
    output logic            nextrowtop,
    output logic            nextrowbot,
    input  logic            colready,
    input  logic            rowtopready,
    input  logic            rowbotready,
    output logic            alu_go,
    input  logic            alu_done,
    output logic [CNTW-1:0] col_idx,
    output logic [CNTW-1:0] row_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_COL_REQ, S_COL_WAIT, S_COL_ALU,
        S_ROW_REQ, S_ROW_WAIT, S_ROW_ALU, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic              bmp_wren_q, nextcol_q, nextrowtop_q, nextrowbot_q;
    logic              alu_go_q, done_q, busy_q, err_q;
    logic [CNTW-1:0]   col_idx_q, row_idx_q;
    logic              top_seen_q, bot_seen_q;

    // Row readiness may arrive in any order; combine the latched flag with this cycle's input.
    logic top_now, bot_now;
    assign top_now = top_seen_q | rowtopready;
    assign bot_now = bot_seen_q | rowbotready;

    // alu_done coinciding with our own alu_go pulse belongs to no slice we issued, so it is ignored.
    logic alu_done_ok;
    assign alu_done_ok = alu_done & ~alu_go_q;

    logic wait_st;
    assign wait_st = (state_q == S_COL_WAIT) || (state_q == S_COL_ALU) ||
                     (state_q == S_ROW_WAIT) || (state_q == S_ROW_ALU);

    // Watchdog (BMP_SCAN_WDOG_EN): counts cycles spent in one waiting state.
    logic tmo;
`ifdef BMP_SCAN_WDOG_EN
    localparam int WDW = $clog2(TMO_CYC + 1);
    logic [WDW-1:0] wdog_q;
    logic           stall;

    assign stall = ((state_q == S_COL_WAIT) && !colready) ||
                   ((state_q == S_COL_ALU)  && !alu_done_ok) ||
                   ((state_q == S_ROW_WAIT) && !(top_now && bot_now)) ||
                   ((state_q == S_ROW_ALU)  && !alu_done_ok);
    assign tmo = wait_st && (wdog_q == WDW'(TMO_CYC - 1));

    // Cycle counter restarts on every state change and only runs while stalled in a wait state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (wait_st && stall) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    logic wdog_unused;
    assign wdog_unused = wait_st & (TMO_CYC != 0);
    assign tmo = 1'b0;
`endif

    // Main sequencer: state, counters and every output are updated together so outputs stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bmp_wren_q   <= 1'b0;
            nextcol_q    <= 1'b0;
            nextrowtop_q <= 1'b0;
            nextrowbot_q <= 1'b0;
            alu_go_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            top_seen_q   <= 1'b0;
            bot_seen_q   <= 1'b0;
        end else begin
            bmp_wren_q   <= 1'b0;
            nextcol_q    <= 1'b0;
            nextrowtop_q <= 1'b0;
            nextrowbot_q <= 1'b0;
            alu_go_q     <= 1'b0;
            done_q       <= 1'b0;
            if (tmo) begin
                // Abort keeps the indices of the stalled slice for debug.
                state_q    <= S_ERR;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                top_seen_q <= 1'b0;
                bot_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_LOAD;
                            bmp_wren_q <= 1'b1;
                            busy_q     <= 1'b1;
                            err_q      <= 1'b0;
                            col_idx_q  <= '0;
                            row_idx_q  <= '0;
                            top_seen_q <= 1'b0;
                            bot_seen_q <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        state_q   <= S_COL_REQ;
                        nextcol_q <= 1'b1;
                    end
                    S_COL_REQ: state_q <= S_COL_WAIT;
                    S_COL_WAIT: begin
                        if (colready) begin
                            state_q  <= S_COL_ALU;
                            alu_go_q <= 1'b1;
                        end
                    end
                    S_COL_ALU: begin
                        if (alu_done_ok) begin
                            if (col_idx_q == CNTW'(NCOLS - 1)) begin
                                state_q      <= S_ROW_REQ;
                                row_idx_q    <= '0;
                                nextrowtop_q <= 1'b1;
                                nextrowbot_q <= 1'b1;
                            end else begin
                                state_q   <= S_COL_REQ;
                                col_idx_q <= col_idx_q + 1'b1;
                                nextcol_q <= 1'b1;
                            end
                        end
                    end
                    S_ROW_REQ: state_q <= S_ROW_WAIT;
                    S_ROW_WAIT: begin
                        if (top_now && bot_now) begin
                            state_q    <= S_ROW_ALU;
                            alu_go_q   <= 1'b1;
                            top_seen_q <= 1'b0;
                            bot_seen_q <= 1'b0;
                        end else begin
                            top_seen_q <= top_now;
                            bot_seen_q <= bot_now;
                        end
                    end
                    S_ROW_ALU: begin
                        if (alu_done_ok) begin
                            if (row_idx_q == CNTW'(NROWS / 2 - 1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q      <= S_ROW_REQ;
                                row_idx_q    <= row_idx_q + 1'b1;
                                nextrowtop_q <= 1'b1;
                                nextrowbot_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    S_ERR:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bmp_wren   = bmp_wren_q;
    assign nextcol    = nextcol_q;
    assign nextrowtop = nextrowtop_q;
    assign nextrowbot = nextrowbot_q;
    assign alu_go     = alu_go_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign col_idx    = col_idx_q;
    assign row_idx    = row_idx_q;

endmodule
